// File: rtl/fft_sdf_stage2.sv
// fft_sdf_stage2: radix-2 DIF SDF stage 2 of the 32-point FFT.
// 8-deep feedback butterfly, difference path rotated by W16^n.
module fft_sdf_stage2 #(
   parameter int IN_W  = 14,
   parameter int OUT_W = 15,
   parameter int TW_W  = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_i,
   input  logic signed [IN_W-1:0]  data_in_r,
   input  logic signed [IN_W-1:0]  data_in_i,
   output logic                    valid_o,
   output logic signed [OUT_W-1:0] data_out_r,
   output logic signed [OUT_W-1:0] data_out_i
);
   localparam int PW = OUT_W + TW_W + 2;
   localparam int SH = TW_W - 2;
   localparam int C_RE [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
   localparam int C_IM [8] = '{0, -98, -181, -237, -256, -237, -181, -98};
   logic [3:0]              r_cnt;
   logic                    r_primed;
   logic signed [OUT_W-1:0] r_dl_r [8];
   logic signed [OUT_W-1:0] r_dl_i [8];
   logic [2:0]              w_n;
   logic                    w_b, w_emit;
   logic signed [OUT_W-1:0] w_xr, w_xi, w_dr, w_di, w_sr, w_si, w_fr, w_fi;
   logic signed [TW_W-1:0]  w_c, w_s;
   logic signed [PW-1:0]    w_pr, w_pi;

   function automatic logic signed [OUT_W-1:0] sat(input logic signed [PW-1:0] v);
      logic signed [PW-1:0] s;
      s = v >>> SH;
      return s > PW'(2**(OUT_W-1) - 1) ? {1'b0, {(OUT_W-1){1'b1}}} :
             s < PW'(-(2**(OUT_W-1)))  ? {1'b1, {(OUT_W-1){1'b0}}} : s[OUT_W-1:0];
   endfunction

   assign w_n    = r_cnt[2:0];
   assign w_b    = r_cnt[3];
   assign w_emit = w_b | r_primed;
   assign w_xr   = OUT_W'(data_in_r);
   assign w_xi   = OUT_W'(data_in_i);
   assign w_dr   = r_dl_r[w_n];
   assign w_di   = r_dl_i[w_n];
   assign w_sr   = w_dr + w_xr;
   assign w_si   = w_di + w_xi;
   assign w_fr   = w_dr - w_xr;
   assign w_fi   = w_di - w_xi;
   assign w_c    = TW_W'(C_RE[w_n]);
   assign w_s    = TW_W'(C_IM[w_n]);
   // products carry the rounding half-LSB so sat() only needs to shift
   assign w_pr   = w_dr * w_c - w_di * w_s + PW'(2**(SH-1));
   assign w_pi   = w_di * w_c + w_dr * w_s + PW'(2**(SH-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_primed   <= 1'b0;
         valid_o    <= 1'b0;
         data_out_r <= '0;
         data_out_i <= '0;
      end else begin
         valid_o <= valid_i & w_emit;
         if (valid_i) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) r_primed <= 1'b1;
            if (w_emit) begin
               data_out_r <= w_b ? w_sr : sat(w_pr);
               data_out_i <= w_b ? w_si : sat(w_pi);
            end
         end
      end
   end

   // delay line is never emitted before priming, so it needs no reset
   always_ff @(posedge clk) begin
      if (valid_i) begin
         r_dl_r[w_n] <= w_b ? w_fr : w_xr;
         r_dl_i[w_n] <= w_b ? w_fi : w_xi;
      end
   end
endmodule

// File: tb/tb_fft_sdf_stage2.sv
// tb_fft_sdf_stage2: directed self-checking bench for fft_sdf_stage2.
module tb_fft_sdf_stage2;
   logic              clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0;
   logic signed [13:0] data_in_r = '0, data_in_i = '0;
   logic               valid_o;
   logic signed [14:0] data_out_r, data_out_i;
   int n_pass = 0, n_chk = 0;
   int st_v [64], st_r [64], st_i [64], vo [64];
   int st_len;
   int fr_r [16], fr_i [16], ex_r [16], ex_i [16];
   int got_r [$], got_i [$];

   fft_sdf_stage2 dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
      .data_in_r(data_in_r), .data_in_i(data_in_i),
      .valid_o(valid_o), .data_out_r(data_out_r), .data_out_i(data_out_i)
   );

   always #5 clk = ~clk;

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clear_vectors;
      for (int i = 0; i < 16; i++) begin
         fr_r[i] = 0; fr_i[i] = 0; ex_r[i] = 0; ex_i[i] = 0;
      end
   endtask

   // frame followed by 8 zero drain samples; ga/gb = accepted count after which a 3-cycle gap is inserted
   task automatic build(input int ga, input int gb);
      st_len = 0;
      for (int k = 0; k < 24; k++) begin
         st_v[st_len] = 1;
         st_r[st_len] = k < 16 ? fr_r[k] : 0;
         st_i[st_len] = k < 16 ? fr_i[k] : 0;
         st_len++;
         if (k + 1 == ga || k + 1 == gb)
            for (int g = 0; g < 3; g++) begin
               st_v[st_len] = 0; st_r[st_len] = 77; st_i[st_len] = -33; st_len++;
            end
      end
   endtask

   task automatic run_stim;
      got_r.delete();
      got_i.delete();
      for (int k = 0; k <= st_len; k++) begin
         @(negedge clk);
         if (k > 0) begin
            vo[k-1] = int'(valid_o);
            if (valid_o) begin
               got_r.push_back(int'(data_out_r));
               got_i.push_back(int'(data_out_i));
            end
         end
         if (k < st_len) begin
            valid_i = st_v[k] != 0;
            data_in_r = 14'(st_r[k]);
            data_in_i = 14'(st_i[k]);
         end else valid_i = 1'b0;
      end
   endtask

   task automatic check_outputs(input string nm);
      int acc, bad;
      n_chk++;
      if (got_r.size() !== 16) $display("FAIL %s count: got %0d want 16", nm, got_r.size());
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_chk++;
         if (i >= got_r.size() || got_r[i] !== ex_r[i] || got_i[i] !== ex_i[i])
            $display("FAIL %s out[%0d]: got (%0d,%0d) want (%0d,%0d)", nm, i,
                     i < got_r.size() ? got_r[i] : -99999, i < got_i.size() ? got_i[i] : -99999, ex_r[i], ex_i[i]);
         else n_pass++;
      end
      acc = 0;
      bad = 0;
      for (int k = 0; k < st_len; k++) begin
         if (vo[k] != ((st_v[k] != 0 && acc >= 8) ? 1 : 0)) bad++;
         if (st_v[k] != 0) acc++;
      end
      n_chk++;
      if (bad !== 0) $display("FAIL %s valid_o timing: got %0d bad cycles want 0", nm, bad);
      else n_pass++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_chk++;
         if ({valid_o, data_out_r, data_out_i} !== 31'd0)
            $display("FAIL reset_hold: got v=%0b (%0d,%0d) want 0", valid_o, data_out_r, data_out_i);
         else n_pass++;
         valid_i = 1'($urandom_range(0, 1));
         data_in_r = 14'($urandom);
         data_in_i = 14'($urandom);
      end
      valid_i = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_chk++;
         if ({valid_o, data_out_r, data_out_i} !== 31'd0)
            $display("FAIL reset_idle: got v=%0b (%0d,%0d) want 0", valid_o, data_out_r, data_out_i);
         else n_pass++;
      end
   endtask

   task automatic set_impulse;
      clear_vectors();
      fr_r[0] = 100;
      ex_r[0] = 100;
      ex_r[8] = 100;
   endtask

   task automatic test_impulse;
      do_reset();
      set_impulse();
      build(0, 0);
      run_stim();
      check_outputs("impulse");
   endtask

   task automatic test_twiddle;
      do_reset();
      clear_vectors();
      fr_r[2] = 100;
      ex_r[2] = 100;
      ex_r[10] = 71; ex_i[10] = -71;
      build(0, 0);
      run_stim();
      check_outputs("twiddle");
   endtask

   task automatic test_saturation;
      do_reset();
      clear_vectors();
      fr_r[3] = 8191;  fr_i[3] = 8191;
      fr_r[11] = -8192; fr_i[11] = -8192;
      ex_r[3] = -1;     ex_i[3] = -1;
      ex_r[11] = 16383; ex_i[11] = -8895;
      build(0, 0);
      run_stim();
      check_outputs("saturation");
   endtask

   task automatic test_gapped;
      do_reset();
      set_impulse();
      build(5, 12);
      run_stim();
      check_outputs("gapped");
   endtask

   task automatic test_midframe_reset;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         valid_i = 1'b1;
         data_in_r = 14'sd50;
         data_in_i = 14'sd50;
      end
      @(negedge clk);
      rst_n = 1'b0;
      valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_chk++;
      if ({valid_o, data_out_r, data_out_i} !== 31'd0)
         $display("FAIL midreset_clear: got v=%0b (%0d,%0d) want 0", valid_o, data_out_r, data_out_i);
      else n_pass++;
      set_impulse();
      build(0, 0);
      run_stim();
      check_outputs("midreset");
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_twiddle();
      test_saturation();
      test_gapped();
      test_midframe_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
